rotate_multi: RTL
=================

Name: rotate_multi

Overview:
- Parametrised rotating-square animator for an N-digit seven-segment display.
- A single lit square travels around the display perimeter: lower squares left-to-right along digits 0..N-1, then upper squares back from N-1 to 0.
- Adds over the fixed 4-digit rotator:
  - digit count as a parameter
  - run-time speed select
  - single-step while paused
  - bounce (ping-pong) mode
  - a position/event output for other blocks.
- Output bus feeds the existing SSEG time-multiplexer directly.

Parameters:
- NUM_DIGITS, 4, number of SSEG digits; legal range 2..16.
- POWER, 24, prescaler width; base tick period = 2**POWER clocks; must be >= 4.
- LOW_PATTERN, 8'b10101100, active-low segment code for lower square.
- HIGH_PATTERN, 8'b10011100, active-low segment code for upper square.
- BLANK_PATTERN, 8'b11111111, blank digit.
- Derived localparams: NPOS = 2*NUM_DIGITS; POS_W = clog2(NPOS).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = free-run animation; 0 = paused, timer holds.
- clockwise  in  1  requested direction; 1 = increasing position.
- bounce  in  1  0 = circular wrap; 1 = reflect at position 0 and NPOS-1.
- step  in  1  single-cycle pulse; advances one position when enable=0.
- speed  in  2  rate select; tick period = 2**(POWER-speed) clocks.
- sseg  out  8*NUM_DIGITS  digit d occupies bits [8d+7:8d].
- pos  out  POS_W  current position register.
- wrap  out  1  one-cycle pulse coincident with a wrap or reflection update.

Behaviour:
- Reset (async assert, sync release):
  - pos=0, timer=0, dir=1 (clockwise), wrap=0.
  - sseg: digit0 = LOW_PATTERN, all others BLANK_PATTERN.
- Position decode (combinational from pos):
  - p < N: digit p = LOW_PATTERN.
  - p >= N: digit (2N-1-p) = HIGH_PATTERN.
  - All other digits BLANK_PATTERN; exactly one digit non-blank at all times.
- Timer (POWER bits):
  - terminal = (2**POWER-1) >> speed.
  - When enable=1:
    - if timer >= terminal: tick=1, timer <- 0;
    - else timer <- timer+1.
  - When enable=0: timer holds, tick=0.
  - Using >= makes a speed increase mid-count tick on the next enabled cycle, with no long rollover.
- Advance event:
  - adv = tick OR (step AND NOT enable).
  - step while enable=1 is ignored.
- Direction register dir:
  - While bounce=0: dir <- clockwise every cycle.
  - While bounce=1: dir changes only on reflection; clockwise is ignored.
- On adv, circular mode (bounce=0):
  - dir=1: pos <- (pos==NPOS-1) ? 0 : pos+1.
  - dir=0: pos <- (pos==0) ? NPOS-1 : pos-1.
  - Wrap uses explicit compare, never natural overflow; non-power-of-2 NPOS (e.g. N=3, 5) must wrap correctly.
  - wrap <- 1 on the 0 <-> NPOS-1 transitions.
- On adv, bounce mode:
  - dir=1 and pos==NPOS-1: pos <- NPOS-2, dir <- 0, wrap <- 1.
  - dir=0 and pos==0: pos <- 1, dir <- 1, wrap <- 1.
  - Otherwise step in dir, wrap <- 0.
- wrap timing: registered, high exactly the cycle after the updating edge (same cycle pos shows the new value); 0 whenever there is no adv.
- Latency: tick cycle -> pos and sseg change at the next rising edge.
- Simultaneous events:
  - bounce toggling 0->1 on an adv cycle uses the dir value held before the edge.
  - clockwise change on an adv cycle with bounce=0 uses the old dir; the new direction applies from the next adv.
- Reset mid-operation: all state clears immediately; no partial step completes.
- Any pos outside 0..NPOS-1 is unreachable. Decode must blank all digits for such a value, and the next adv must go to 0.

Test Plan:
- N=4, POWER=4, speed=0, enable=1, cw=1 from reset -> pos 0,1,...,7,0 every 16 clocks; wrap pulses on the 7->0 update; sseg digit3 = 8'b10011100 when pos=4.
- N=3, POWER=4, cw=0 from reset -> first adv pos 0->5 with wrap=1; digit0 = HIGH_PATTERN at pos=5; sequence continues 5,4,3,2,1,0.
- N=4, bounce=1, cw=1, speed=3 -> tick every 2 clocks; pos 0..7,6,5,...,0,1; wrap only at the 7->6 and 0->1 updates.
- enable=0, three step pulses separated by idle cycles -> pos 0->1->2->3, one per pulse, timer stays 0; step held with enable=1 -> ignored.
- Timer at 12 with speed=0, switch to speed=2 (terminal 3) -> tick on the next cycle, then every 4 clocks.
- Assert reset_n low asynchronously mid-count at pos=5 -> pos=0, sseg = {BLANK,BLANK,BLANK,LOW} before the next clock edge, wrap=0.

Source files
------------

// File: rtl/rotate_multi.sv
// rotate_multi: rotating-square animator for an N-digit seven-segment display.
// A single lit square walks the display perimeter: the lower squares run
// left-to-right over digits 0..N-1 (positions 0..N-1), then the upper squares
// run back from digit N-1 to digit 0 (positions N..2N-1).
// The animation rate can be selected at run time. It can also be paused and
// single-stepped, or run in ping-pong (bounce) mode.
// pos and a wrap/reflect pulse are exported so other blocks can follow it.
// sseg drives the existing SSEG time-multiplexer directly.
// reset_n asserts asynchronously. Its release is expected to be synchronous to clk.

module rotate_multi #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned POWER         = 24,
    parameter logic [7:0]  LOW_PATTERN   = 8'b10101100,
    parameter logic [7:0]  HIGH_PATTERN  = 8'b10011100,
    parameter logic [7:0]  BLANK_PATTERN = 8'b11111111,
    localparam int unsigned NPOS         = 2 * NUM_DIGITS,
    localparam int unsigned POS_W        = $clog2(NPOS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    clockwise,
    input  logic                    bounce,
    input  logic                    step,
    input  logic [1:0]              speed,
    output logic [8*NUM_DIGITS-1:0] sseg,
    output logic [POS_W-1:0]        pos,
    output logic                    wrap
);

    // Last legal position, in pos width and in a one-bit-wider form.
    // The wider form lets the out-of-range test stay meaningful when NPOS is a power of two.
    localparam logic [POS_W-1:0] LAST_POS     = POS_W'(NPOS - 1);
    localparam logic [POS_W:0]   LAST_POS_EXT = (POS_W + 1)'(NPOS - 1);
    localparam logic [POS_W-1:0] ONE_POS      = POS_W'(1);

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [POWER-1:0] timer;
    logic [POWER-1:0] terminal;
    logic             tick;
    logic             adv;

    // Terminal count shrinks by a power of two per speed step.
    // Ticking on timer >= terminal means that raising the speed mid-count
    // fires on the next enabled cycle. There is no long rollover through 2**POWER.
    assign terminal = {POWER{1'b1}} >> speed;
    assign tick     = enable && (timer >= terminal);

    // Advance on a timer tick, or on a manual step while paused.
    // A step received while running is dropped.
    assign adv = tick || (step && !enable);

    // Free-running prescaler: it counts only while enabled and restarts from 0 after each tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (enable) begin
            if (tick) begin
                timer <= '0;
            end else begin
                timer <= timer + POWER'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Position / direction next-state
    // ------------------------------------------------------------------
    logic             dir;
    logic             dir_next;
    logic [POS_W-1:0] pos_next;
    logic             wrap_next;
    logic             pos_bad;

    assign pos_bad = ({1'b0, pos} > LAST_POS_EXT);

    // Next position, direction and wrap flag.
    // Every step uses the direction held before the edge, so a clockwise or
    // bounce change on an advance cycle takes effect on the following advance.
    always_comb begin
        pos_next  = pos;
        dir_next  = bounce ? dir : clockwise;
        wrap_next = 1'b0;
        if (adv) begin
            if (pos_bad) begin
                // Recover from an illegal position by restarting at 0.
                pos_next = '0;
            end else if (!bounce) begin
                // Circular mode: wrap using an explicit compare, so non-power-of-two NPOS works.
                if (dir) begin
                    if (pos == LAST_POS) begin
                        pos_next  = '0;
                        wrap_next = 1'b1;
                    end else begin
                        pos_next = pos + ONE_POS;
                    end
                end else begin
                    if (pos == '0) begin
                        pos_next  = LAST_POS;
                        wrap_next = 1'b1;
                    end else begin
                        pos_next = pos - ONE_POS;
                    end
                end
            end else begin
                // Bounce mode: reflect at either end and flip direction.
                if (dir && (pos == LAST_POS)) begin
                    pos_next  = LAST_POS - ONE_POS;
                    dir_next  = 1'b0;
                    wrap_next = 1'b1;
                end else if (!dir && (pos == '0)) begin
                    pos_next  = ONE_POS;
                    dir_next  = 1'b1;
                    wrap_next = 1'b1;
                end else if (dir) begin
                    pos_next = pos + ONE_POS;
                end else begin
                    pos_next = pos - ONE_POS;
                end
            end
        end
    end

    // Position, direction and wrap-pulse registers.
    // wrap is high for exactly the cycle in which pos shows the new value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos  <= '0;
            dir  <= 1'b1;
            wrap <= 1'b0;
        end else begin
            pos  <= pos_next;
            dir  <= dir_next;
            wrap <= wrap_next;
        end
    end

    // ------------------------------------------------------------------
    // Segment decode
    // ------------------------------------------------------------------
    // Digit d shows the lower square at position d and the upper square at position 2N-1-d.
    // An out-of-range pos matches no digit, so the display blanks.
    always_comb begin
        sseg = {NUM_DIGITS{BLANK_PATTERN}};
        for (int d = 0; d < int'(NUM_DIGITS); d++) begin
            if (pos == POS_W'(d)) begin
                sseg[8*d +: 8] = LOW_PATTERN;
            end else if (pos == POS_W'(int'(NPOS) - 1 - d)) begin
                sseg[8*d +: 8] = HIGH_PATTERN;
            end
        end
    end

endmodule
